// File: rtl/env_gen_multi.sv
// env_gen_multi: multi-channel ADSR envelope generator with hold, release and loop/wait.
// Define ENV_EXP_RELEASE_EN for an exponential release curve (step = max(1, vol>>3)).
module env_gen_multi #(
  parameter int NUM_CH = 4,
  parameter int VOL_W = 6,
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk_8khz,
  input  logic                    reset_n,
  input  logic                    cfg_we,
  input  logic [CH_W-1:0]         cfg_ch,
  input  logic [1:0]              cfg_addr,
  input  logic [7:0]              cfg_data,
  input  logic [NUM_CH-1:0]       key_on,
  input  logic [NUM_CH-1:0]       key_off,
  output logic [NUM_CH*VOL_W-1:0] env_vol,
  output logic [NUM_CH-1:0]       env_busy,
  output logic [NUM_CH-1:0]       env_done
);
  typedef enum logic [2:0] {IDLE, ATTACK, DECAY, SUSTAIN, RELEASE, WAIT} state_t;
  localparam logic [VOL_W-1:0] MAX = '1;
  localparam logic [7:0] RATE [16] = '{8'd2, 8'd5, 8'd15, 8'd30, 8'd45, 8'd60, 8'd70, 8'd80,
                                       8'd90, 8'd100, 8'd110, 8'd120, 8'd140, 8'd170, 8'd200, 8'd250};
  genvar c;
  generate
    for (c = 0; c < NUM_CH; c++) begin : g_ch
      state_t state, state_nx;
      logic [13:0] cnt, cnt_nx, per;
      logic [VOL_W-1:0] vol, vol_nx, dec, rel_vol, sus_lvl;
      logic [3:0] atk, dcy, sus_t, rel;
      logic [1:0] loop_dly;
      logic loop_en, hold, done, done_nx, we, step;
      assign we = cfg_we && cfg_ch == CH_W'(c);
      assign per = state == ATTACK  ? 14'(RATE[atk]) :
                   state == DECAY   ? {RATE[dcy], 6'd0} :
                   state == SUSTAIN ? {RATE[sus_t], 6'd0} :
                   state == WAIT    ? {RATE[{loop_dly, 2'b00}], 6'd0} : 14'(RATE[rel]);
      assign step = state != IDLE && cnt == per - 14'd1;
`ifdef ENV_EXP_RELEASE_EN
      assign dec = vol[VOL_W-1:3] == '0 ? VOL_W'(1) : VOL_W'(vol >> 3);
`else
      assign dec = VOL_W'(1);
`endif
      assign rel_vol = vol > dec ? vol - dec : '0;
      // key events take priority over a coinciding step
      always_comb begin
        state_nx = state;
        vol_nx = vol;
        done_nx = 1'b0;
        if (key_on[c]) state_nx = ATTACK;
        else if (key_off[c] && (state == ATTACK || state == DECAY || state == SUSTAIN)) state_nx = RELEASE;
        else if (step)
          case (state)
            ATTACK:  if (vol == MAX) state_nx = DECAY; else vol_nx = vol + 1'b1;
            DECAY:   if (vol > sus_lvl) vol_nx = vol - 1'b1; else state_nx = SUSTAIN;
            SUSTAIN: if (!hold) state_nx = RELEASE;
            RELEASE: begin
              vol_nx = rel_vol;
              done_nx = rel_vol == '0;
              if (rel_vol == '0) state_nx = loop_en ? WAIT : IDLE;
            end
            WAIT:    state_nx = ATTACK;
            default: ;
          endcase
        cnt_nx = (key_on[c] || step || state_nx != state || state_nx == IDLE) ? '0 : cnt + 1'b1;
      end
      always_ff @(posedge clk_8khz) begin
        if (!reset_n) begin
          state <= IDLE;
          cnt <= '0;
          vol <= '0;
          done <= 1'b0;
          sus_lvl <= '0;
          {atk, dcy, sus_t, rel} <= '0;
          {loop_en, loop_dly, hold} <= '0;
        end else begin
          state <= state_nx;
          cnt <= cnt_nx;
          vol <= vol_nx;
          done <= done_nx;
          if (we && cfg_addr == 2'd0) sus_lvl <= cfg_data[7 -: VOL_W];
          if (we && cfg_addr == 2'd1) {atk, dcy} <= cfg_data;
          if (we && cfg_addr == 2'd2) {sus_t, rel} <= cfg_data;
          if (we && cfg_addr == 2'd3) {loop_en, loop_dly, hold} <= cfg_data[7:4];
        end
      end
      assign env_vol[c*VOL_W +: VOL_W] = vol;
      assign env_busy[c] = state != IDLE;
      assign env_done[c] = done;
    end
  endgenerate
endmodule

// File: tb/tb_env_gen_multi.sv
// tb_env_gen_multi: directed and randomized checks of env_gen_multi against a cycle model.
module tb_env_gen_multi;
  localparam int NCH = 4, VW = 6, MAXV = 63;
  localparam int M_IDLE = 0, M_ATK = 1, M_DCY = 2, M_SUS = 3, M_REL = 4, M_WAIT = 5;
  localparam int RATE [16] = '{2, 5, 15, 30, 45, 60, 70, 80, 90, 100, 110, 120, 140, 170, 200, 250};
  logic clk_8khz = 1'b0, reset_n = 1'b0, cfg_we = 1'b0;
  logic [1:0] cfg_ch = '0, cfg_addr = '0;
  logic [7:0] cfg_data = '0;
  logic [NCH-1:0] key_on = '0, key_off = '0;
  logic [NCH*VW-1:0] env_vol;
  logic [NCH-1:0] env_busy, env_done;
  int checks = 0, errors = 0;
  int m_st [NCH], m_vol [NCH], m_age [NCH];
  int m_reg [NCH][4];
  logic [NCH*VW-1:0] exp_vol;
  logic [NCH-1:0] exp_busy, exp_done;

  env_gen_multi #(.NUM_CH(NCH), .VOL_W(VW)) dut (
    .clk_8khz(clk_8khz), .reset_n(reset_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .key_on(key_on), .key_off(key_off),
    .env_vol(env_vol), .env_busy(env_busy), .env_done(env_done));

  always #5 clk_8khz = ~clk_8khz;

  function automatic int period(int ch);
    case (m_st[ch])
      M_ATK:   return RATE[m_reg[ch][1] / 16];
      M_DCY:   return RATE[m_reg[ch][1] % 16] * 64;
      M_SUS:   return RATE[m_reg[ch][2] / 16] * 64;
      M_REL:   return RATE[m_reg[ch][2] % 16];
      M_WAIT:  return RATE[((m_reg[ch][3] / 32) % 4) * 4] * 64;
      default: return 0;
    endcase
  endfunction

  function automatic int release_drop(int v);
`ifdef ENV_EXP_RELEASE_EN
    return v / 8 > 1 ? v / 8 : 1;
`else
    return 1;
`endif
  endfunction

  function automatic int vol_of(int ch);
    return int'(env_vol[ch*VW +: VW]);
  endfunction

  // model: each step point evaluated from the rules, age counts cycles since last entry/step
  task automatic model_step();
    for (int ch = 0; ch < NCH; ch++) begin
      int ns, nv;
      bit stepped, fire;
      if (!reset_n) begin
        m_st[ch] = M_IDLE; m_vol[ch] = 0; m_age[ch] = 0;
        for (int r = 0; r < 4; r++) m_reg[ch][r] = 0;
        exp_done[ch] = 1'b0;
      end else begin
        stepped = m_st[ch] != M_IDLE && m_age[ch] == period(ch) - 1;
        ns = m_st[ch]; nv = m_vol[ch]; fire = 0;
        if (key_on[ch]) ns = M_ATK;
        else if (key_off[ch] && (m_st[ch] == M_ATK || m_st[ch] == M_DCY || m_st[ch] == M_SUS)) ns = M_REL;
        else if (stepped) begin
          if (m_st[ch] == M_ATK) begin
            if (m_vol[ch] == MAXV) ns = M_DCY; else nv = m_vol[ch] + 1;
          end else if (m_st[ch] == M_DCY) begin
            if (m_vol[ch] > m_reg[ch][0] / (1 << (8 - VW))) nv = m_vol[ch] - 1; else ns = M_SUS;
          end else if (m_st[ch] == M_SUS) begin
            if ((m_reg[ch][3] / 16) % 2 == 0) ns = M_REL;
          end else if (m_st[ch] == M_REL) begin
            nv = m_vol[ch] - release_drop(m_vol[ch]);
            if (nv <= 0) begin
              nv = 0; fire = 1;
              ns = m_reg[ch][3] >= 128 ? M_WAIT : M_IDLE;
            end
          end else if (m_st[ch] == M_WAIT) ns = M_ATK;
        end
        m_age[ch] = (key_on[ch] || stepped || ns != m_st[ch] || ns == M_IDLE) ? 0 : (m_age[ch] + 1) % 16384;
        m_st[ch] = ns; m_vol[ch] = nv; exp_done[ch] = fire;
        if (cfg_we && int'(cfg_ch) == ch) m_reg[ch][cfg_addr] = int'(cfg_data);
      end
      exp_vol[ch*VW +: VW] = VW'(m_vol[ch]);
      exp_busy[ch] = m_st[ch] != M_IDLE;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk_8khz);
    #1;
  endtask

  task automatic write_reg(input int ch, input int addr, input int data);
    cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_addr = 2'(addr); cfg_data = 8'(data);
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic pulse_on(input logic [NCH-1:0] m);
    key_on = m; tick(); key_on = '0;
  endtask

  task automatic pulse_off(input logic [NCH-1:0] m);
    key_off = m; tick(); key_off = '0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; key_on = '1; cfg_we = 1'b1;
    repeat (3) tick();
    checks++; if (env_vol !== '0) begin errors++; $display("FAIL reset_vol got %h exp 0", env_vol); end
    checks++; if (env_busy !== '0) begin errors++; $display("FAIL reset_busy got %b exp 0", env_busy); end
    checks++; if (env_done !== '0) begin errors++; $display("FAIL reset_done got %b exp 0", env_done); end
    key_on = '0; cfg_we = 1'b0; reset_n = 1'b1;
    tick();
    checks++; if (env_busy !== '0) begin errors++; $display("FAIL reset_idle got %b exp 0", env_busy); end
  endtask

  task automatic test_attack_decay();
    int nd = 0;
    pulse_on(4'b0001);
    checks++; if (env_busy[0] !== 1'b1) begin errors++; $display("FAIL ad_busy got %b exp 1", env_busy[0]); end
    repeat (125) tick();
    checks++; if (vol_of(0) != 62) begin errors++; $display("FAIL ad_vol125 got %0d exp 62", vol_of(0)); end
    tick();
    checks++; if (vol_of(0) != 63) begin errors++; $display("FAIL ad_vol126 got %0d exp 63", vol_of(0)); end
    repeat (8200) tick();
    checks++; if (vol_of(0) != 0 || env_busy[0] !== 1'b1) begin errors++; $display("FAIL ad_decay got vol %0d busy %b exp 0 1", vol_of(0), env_busy[0]); end
    checks++; if (env_vol !== exp_vol) begin errors++; $display("FAIL ad_model got %h exp %h", env_vol, exp_vol); end
    repeat (200) begin tick(); nd += int'(env_done[0]); end
    checks++; if (nd != 1 || env_busy[0] !== 1'b0) begin errors++; $display("FAIL ad_done got pulses %0d busy %b exp 1 0", nd, env_busy[0]); end
  endtask

  task automatic test_hold_release();
    int nd = 0;
    write_reg(1, 0, 8'h80);
    write_reg(1, 3, 8'h10);
    pulse_on(4'b0010);
    repeat (20000) tick();
    checks++; if (vol_of(1) != 32 || env_busy[1] !== 1'b1) begin errors++; $display("FAIL hold_level got %0d exp 32", vol_of(1)); end
    pulse_off(4'b0010);
    repeat (2) tick();
`ifdef ENV_EXP_RELEASE_EN
    checks++; if (vol_of(1) != 28) begin errors++; $display("FAIL hold_rel1 got %0d exp 28", vol_of(1)); end
`else
    checks++; if (vol_of(1) != 31) begin errors++; $display("FAIL hold_rel1 got %0d exp 31", vol_of(1)); end
`endif
    repeat (100) begin
      tick(); nd += int'(env_done[1]);
      checks++; if (env_vol !== exp_vol || env_done !== exp_done) begin errors++; $display("FAIL hold_rel_model got %h/%b exp %h/%b", env_vol, env_done, exp_vol, exp_done); end
    end
    checks++; if (nd != 1 || env_busy[1] !== 1'b0 || vol_of(1) != 0) begin errors++; $display("FAIL hold_done got pulses %0d busy %b exp 1 0", nd, env_busy[1]); end
  endtask

  task automatic test_retrigger();
    int n = 0, nd = 0;
    pulse_on(4'b0100);
    repeat (80) tick();
    checks++; if (vol_of(2) != 40) begin errors++; $display("FAIL retrig_atk got %0d exp 40", vol_of(2)); end
    pulse_off(4'b0100);
    while (m_vol[2] != 20 && n < 200) begin tick(); n++; nd += int'(env_done[2]); end
    checks++; if (vol_of(2) != 20) begin errors++; $display("FAIL retrig_rel got %0d exp 20", vol_of(2)); end
    pulse_on(4'b0100);
    nd += int'(env_done[2]);
    checks++; if (vol_of(2) != 20 || env_busy[2] !== 1'b1) begin errors++; $display("FAIL retrig_hold got %0d exp 20", vol_of(2)); end
    repeat (10) begin tick(); nd += int'(env_done[2]); end
    checks++; if (vol_of(2) != 25) begin errors++; $display("FAIL retrig_climb got %0d exp 25", vol_of(2)); end
    checks++; if (nd != 0) begin errors++; $display("FAIL retrig_done got %0d exp 0", nd); end
  endtask

  task automatic test_same_cycle();
    pulse_on(4'b0011);
    repeat (4400) tick();
    checks++; if (vol_of(1) != 32) begin errors++; $display("FAIL same_sus got %0d exp 32", vol_of(1)); end
    key_on = 4'b0010; key_off = 4'b0010;
    tick();
    key_on = '0; key_off = '0;
    checks++; if (vol_of(1) != 32 || env_busy[1] !== 1'b1) begin errors++; $display("FAIL same_attack got %0d exp 32", vol_of(1)); end
    checks++; if (vol_of(0) != m_vol[0] || env_busy[0] !== exp_busy[0]) begin errors++; $display("FAIL same_ch0 got %0d exp %0d", vol_of(0), m_vol[0]); end
    repeat (4) tick();
    checks++; if (vol_of(1) != 34) begin errors++; $display("FAIL same_climb got %0d exp 34", vol_of(1)); end
    checks++; if (env_vol !== exp_vol) begin errors++; $display("FAIL same_model got %h exp %h", env_vol, exp_vol); end
  endtask

  task automatic test_loop();
    int n = 0, bad = 0;
    write_reg(3, 3, 8'h80);
    pulse_on(4'b1000);
    while (env_done[3] !== 1'b1 && n < 10000) begin tick(); n++; end
    checks++; if (env_done[3] !== 1'b1 || exp_done[3] !== 1'b1) begin errors++; $display("FAIL loop_done got %b exp 1 (model %b)", env_done[3], exp_done[3]); end
    repeat (128) begin tick(); bad += int'(vol_of(3) != 0 || env_busy[3] !== 1'b1); end
    checks++; if (bad != 0) begin errors++; $display("FAIL loop_wait got %0d bad cycles exp 0", bad); end
    repeat (2) tick();
    checks++; if (vol_of(3) != 1) begin errors++; $display("FAIL loop_restart got %0d exp 1", vol_of(3)); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      cfg_we = $urandom_range(0, 5) == 0;
      cfg_ch = 2'($urandom_range(0, 3));
      cfg_addr = 2'($urandom_range(0, 3));
      cfg_data = 8'($urandom);
      for (int ch = 0; ch < NCH; ch++) begin
        key_on[ch] = $urandom_range(0, 49) == 0;
        key_off[ch] = $urandom_range(0, 29) == 0;
      end
      tick();
      checks++; if (env_vol !== exp_vol) begin errors++; $display("FAIL rnd_vol cyc %0d got %h exp %h", i, env_vol, exp_vol); end
      checks++; if (env_busy !== exp_busy) begin errors++; $display("FAIL rnd_busy cyc %0d got %b exp %b", i, env_busy, exp_busy); end
      checks++; if (env_done !== exp_done) begin errors++; $display("FAIL rnd_done cyc %0d got %b exp %b", i, env_done, exp_done); end
    end
    cfg_we = 1'b0; key_on = '0; key_off = '0;
  endtask

  task automatic test_reset_mid();
    reset_n = 1'b0; tick(); reset_n = 1'b1; tick();
    pulse_on(4'b1111);
    repeat (20) tick();
    reset_n = 1'b0; key_on = '1; key_off = '1; cfg_we = 1'b1; cfg_ch = 2'd0; cfg_addr = 2'd1; cfg_data = 8'hff;
    tick();
    checks++; if (env_vol !== '0 || env_busy !== '0 || env_done !== '0) begin errors++; $display("FAIL rstmid got %h %b %b exp 0", env_vol, env_busy, env_done); end
    reset_n = 1'b1; key_on = '0; key_off = '0; cfg_we = 1'b0;
    tick();
    pulse_on(4'b0001);
    repeat (126) tick();
    checks++; if (vol_of(0) != 63 || env_vol[NCH*VW-1:VW] !== '0) begin errors++; $display("FAIL rstmid_cfg got %h exp vol0 63 others 0", env_vol); end
    pulse_off(4'b0001);
    repeat (2) tick();
`ifdef ENV_EXP_RELEASE_EN
    checks++; if (vol_of(0) != 56) begin errors++; $display("FAIL rel_step1 got %0d exp 56", vol_of(0)); end
    repeat (2) tick();
    checks++; if (vol_of(0) != 49) begin errors++; $display("FAIL rel_step2 got %0d exp 49", vol_of(0)); end
`else
    checks++; if (vol_of(0) != 62) begin errors++; $display("FAIL rel_step1 got %0d exp 62", vol_of(0)); end
    repeat (2) tick();
    checks++; if (vol_of(0) != 61) begin errors++; $display("FAIL rel_step2 got %0d exp 61", vol_of(0)); end
`endif
    checks++; if (env_vol !== exp_vol) begin errors++; $display("FAIL rel_model got %h exp %h", env_vol, exp_vol); end
  endtask

  initial begin
    test_reset();
    test_attack_decay();
    test_hold_release();
    test_retrigger();
    test_same_cycle();
    test_loop();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/env_gen_multi.md
ENV_GEN_MULTI -- requirements
Module: env_gen_multi

Interface
REQ-001 Parameter NUM_CH, default 4, number of independent envelope channels (1..8).
REQ-002 Parameter VOL_W, default 6, envelope volume width in bits (4..8); MAX = 2^VOL_W-1.
REQ-003 clk_8khz  in  1  8 kHz envelope tick clock; all state changes on its rising edge.
REQ-004 reset_n  in  1  synchronous, active-low reset.
REQ-005 cfg_we  in  1  config write strobe, one register written per cycle.
REQ-006 cfg_ch  in  clog2(NUM_CH) (min 1)  target channel; writes with cfg_ch >= NUM_CH are ignored.
REQ-007 cfg_addr  in  2  register select 0..3.
REQ-008 cfg_data  in  8  write data.
REQ-009 key_on  in  NUM_CH  per-channel trigger, level-sampled each cycle.
REQ-010 key_off  in  NUM_CH  per-channel release request, level-sampled each cycle.
REQ-011 env_vol  out  NUM_CH*VOL_W  registered volume, channel c at bits [c*VOL_W +: VOL_W].
REQ-012 env_busy  out  NUM_CH  high while the channel state is not IDLE.
REQ-013 env_done  out  NUM_CH  one-cycle pulse when RELEASE reaches volume 0.

Function
REQ-014 Per-channel registers: reg0 sustain level, sus_lvl = reg0[7:8-VOL_W]; reg1 atk[7:4], dcy[3:0]; reg2 sus_t[7:4], rel[3:0]; reg3 loop_en[7], loop_dly[6:5], hold[4], [3:0] reserved (read as 0).
REQ-015 RATE[0..15] = 2,5,15,30,45,60,70,80,90,100,110,120,140,170,200,250 ticks.
REQ-016 Step period P: ATTACK RATE[atk]; DECAY RATE[dcy]*64; SUSTAIN RATE[sus_t]*64; RELEASE RATE[rel]; WAIT RATE[loop_dly*4]*64; the tick counter is 14 bits wide.
REQ-017 Tick counter is cleared on every state entry; a step occurs when counter == P-1, and the counter is then cleared.
REQ-018 States: IDLE, ATTACK, DECAY, SUSTAIN, RELEASE, WAIT; each channel runs independently.
REQ-019 key_on=1 in any state: next cycle the state is ATTACK; volume is retained (legato retrigger, no drop to 0).
REQ-020 key_off=1 in ATTACK, DECAY or SUSTAIN: next cycle the state is RELEASE; in IDLE, RELEASE or WAIT it is ignored.
REQ-021 key_on and key_off asserted in the same cycle: key_on wins.
REQ-022 ATTACK step: if vol < MAX, increment; if vol == MAX, enter DECAY.
REQ-023 DECAY step: if vol > sus_lvl, decrement; otherwise enter SUSTAIN.
REQ-024 SUSTAIN: with hold=1, stay until key_off; with hold=0, enter RELEASE at the first step.
REQ-025 RELEASE step: decrement per REQ-034, saturating at 0; at the step that yields 0, pulse env_done and enter WAIT if loop_en, else IDLE.
REQ-026 WAIT: vol held at 0; at the first step, enter ATTACK.
REQ-027 A config write takes effect from the next cycle, including the period compare of an in-progress step; the tick counter is not cleared by the write.
REQ-028 A config write and a key event on the same channel in the same cycle are both applied.

Reset
REQ-029 While reset_n=0 at a clock edge, every channel state goes to IDLE, its tick counter to 0, and all config registers to 0x00.
REQ-030 Output reset values: env_vol=0, env_busy=0, env_done=0.
REQ-031 Reset overrides key_on, key_off and cfg_we in the same cycle, and aborts an operation in progress with no env_done pulse.

Configuration
REQ-032 The macro ENV_EXP_RELEASE_EN selects the release curve.
REQ-033 Without ENV_EXP_RELEASE_EN, each RELEASE step decrements the volume by 1.
REQ-034 With ENV_EXP_RELEASE_EN defined, each RELEASE step decrements the volume by max(1, vol>>3), saturating at 0; all other behaviour is identical.

Verification
REQ-035 All config 0, key_on ch0 held 1 cycle -> busy=1 next cycle; env_vol ch0 reaches 63 after 126 cycles; DECAY reaches 0 after a further 63*128 cycles (plus the SUSTAIN entry step).
REQ-036 hold=1, sus_lvl reg0=0x80 (VOL_W=6 gives 32), key_off after 20000 cycles -> vol held at 32, then drops 1 per 2 cycles; env_done pulses once at vol 0; busy then clears.
REQ-037 key_on during RELEASE at vol=20 -> ATTACK next cycle, vol continues from 20 upward, no env_done pulse.
REQ-038 key_on and key_off high together on ch1 during SUSTAIN -> ATTACK; ch0 unaffected.
REQ-039 loop_en=1, loop_dly=0 -> after env_done, vol=0 for 128 cycles, then ATTACK restarts with no key_on.
REQ-040 Reset asserted mid-ATTACK -> next cycle all outputs 0 and config reads back 0; with ENV_EXP_RELEASE_EN, release from 63 steps 63,56,49,...
